// File: rtl/lpmul_vseq_pkg.sv
// Shared types for the lpmul vector sequencer: lane/product types, the
// lpmul request/response payloads and the sequencer state encoding.
package lpmul_vseq_pkg;

    localparam int unsigned NLANES_DEF = 4;
    localparam int unsigned LANE_W     = 8;
    localparam int unsigned PROD_W     = 16;

    typedef logic [LANE_W-1:0] vector_component;
    typedef logic [PROD_W-1:0] high_prec_component;

    typedef struct packed {
        vector_component a;
        vector_component b;
        logic            sign;
        logic            sat;
    } lpmul_in_type;

    typedef struct packed {
        high_prec_component mul_res;
    } lpmul_out_type;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } lpmul_seq_state_t;

endpackage

// File: rtl/lpmul_vseq_if.sv
// Operand/result handshake bundle between the vector unit and the sequencer.
//   in_valid/in_ready   : operand set handshake (opA, opB, sign, sat)
//   out_valid/out_ready : result handshake (lane_res, dot_res)
// master = vector unit side, slave = sequencer side.
interface lpmul_vseq_if
    import lpmul_vseq_pkg::*;
#(
    parameter int unsigned NLANES = NLANES_DEF
);
    localparam int unsigned DOT_W = PROD_W + $clog2(NLANES);

    logic                       in_valid;
    logic                       in_ready;
    logic [LANE_W*NLANES-1:0]   opA;
    logic [LANE_W*NLANES-1:0]   opB;
    logic                       sign;
    logic                       sat;
    logic                       out_valid;
    logic                       out_ready;
    logic [PROD_W*NLANES-1:0]   lane_res;
    logic [DOT_W-1:0]           dot_res;

    modport master (
        output in_valid, opA, opB, sign, sat, out_ready,
        input  in_ready, out_valid, lane_res, dot_res
    );

    modport slave (
        input  in_valid, opA, opB, sign, sat, out_ready,
        output in_ready, out_valid, lane_res, dot_res
    );

endinterface

// File: rtl/lpmul_vseq_lpmul.sv
// Combinational 8x8 low-precision multiplier for one lane.
//   mul_in    : operands a/b plus sign (two's complement) and sat controls
//   mul_out_c : 16-bit product, optionally clamped to the 8-bit range
module lpmul_vseq_lpmul
    import lpmul_vseq_pkg::*;
(
    input  lpmul_in_type  mul_in,
    output lpmul_out_type mul_out_c
);

    logic               neg_a;
    logic               neg_b;
    logic               neg;
    vector_component    mag_a;
    vector_component    mag_b;
    high_prec_component mag_p;

    // Multiply magnitudes, then reapply the sign; -128 maps to magnitude 0x80.
    always_comb begin
        neg_a = mul_in.sign & mul_in.a[LANE_W-1];
        neg_b = mul_in.sign & mul_in.b[LANE_W-1];
        neg   = neg_a ^ neg_b;
        mag_a = neg_a ? vector_component'(~mul_in.a + 8'd1) : mul_in.a;
        mag_b = neg_b ? vector_component'(~mul_in.b + 8'd1) : mul_in.b;
        mag_p = 16'(mag_a) * 16'(mag_b);

        mul_out_c.mul_res = neg ? high_prec_component'(~mag_p + 16'd1) : mag_p;
        if (mul_in.sat) begin
            if (mul_in.sign) begin
                if (!neg && mag_p > 16'd127) begin
                    mul_out_c.mul_res = 16'h007F;
                end else if (neg && mag_p > 16'd128) begin
                    mul_out_c.mul_res = 16'hFF80;
                end
            end else if (mag_p > 16'd255) begin
                mul_out_c.mul_res = 16'h00FF;
            end
        end
    end

endmodule

// File: rtl/lpmul_vseq.sv
// Sequencer feeding one shared lpmul with one lane per cycle and collecting
// the lane products plus their extended sum (dot product).
//   clk, rstn : clock, asynchronous active-low reset
//   flush     : synchronous abort back to IDLE (results left stale)
//   bus       : operand/result handshake bundle (slave side)
module lpmul_vseq
    import lpmul_vseq_pkg::*;
#(
    parameter int unsigned NLANES = NLANES_DEF
)
(
    input  logic         clk,
    input  logic         rstn,
    input  logic         flush,
    lpmul_vseq_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(NLANES);
    localparam int unsigned DOT_W = PROD_W + CNT_W;

    lpmul_seq_state_t                  state;
    logic [CNT_W-1:0]                  cnt;
    logic [NLANES-1:0][LANE_W-1:0]     op_a;
    logic [NLANES-1:0][LANE_W-1:0]     op_b;
    logic                              sign_q;
    logic                              sat_q;
    logic [NLANES-1:0][PROD_W-1:0]     lane_res_q;
    logic [DOT_W-1:0]                  acc;

    lpmul_in_type                      mul_in;
    lpmul_out_type                     mul_out_c;
    logic [DOT_W-1:0]                  ext_c;

    // Present the current latched lane to the shared multiplier.
    always_comb begin
        mul_in.a    = op_a[cnt];
        mul_in.b    = op_b[cnt];
        mul_in.sign = sign_q;
        mul_in.sat  = sat_q;
    end

    lpmul_vseq_lpmul u_lpmul (
        .mul_in    (mul_in),
        .mul_out_c (mul_out_c)
    );

    // Widen the lane product to the accumulator width before summing.
    always_comb begin
        if (sign_q) begin
            ext_c = {{CNT_W{mul_out_c.mul_res[PROD_W-1]}}, mul_out_c.mul_res};
        end else begin
            ext_c = {{CNT_W{1'b0}}, mul_out_c.mul_res};
        end
    end

    // Sequencer FSM; flush wins over both handshakes.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            cnt        <= '0;
            op_a       <= '0;
            op_b       <= '0;
            sign_q     <= 1'b0;
            sat_q      <= 1'b0;
            lane_res_q <= '0;
            acc        <= '0;
        end else if (flush) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        op_a   <= bus.opA;
                        op_b   <= bus.opB;
                        sign_q <= bus.sign;
                        sat_q  <= bus.sat;
                        acc    <= '0;
                        cnt    <= '0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    lane_res_q[cnt] <= mul_out_c.mul_res;
                    acc             <= acc + ext_c;
                    cnt             <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(NLANES - 1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Handshake flags decode straight from the state register.
    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.lane_res  = lane_res_q;
    assign bus.dot_res   = acc;

endmodule
